// File: rtl/fifo_replay.sv
// Show-ahead FIFO with a replay (circular) mode: reads either consume entries
// or walk the stored window repeatedly without consuming it.
module fifo_replay #(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 32,
  parameter int ALMOST_FULL_FREE   = 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         circular,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             dout,
  output logic                         valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FULLV = FW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr, r_head, r_cur;
  logic [FW-1:0]    r_fill;
  logic             r_circ, r_over, r_under;

  logic             w_rdOk, w_wrOk, w_consume;
  logic [PW-1:0]    w_headNext, w_curInc, w_curNext;
  logic [FW-1:0]    w_fillNext;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO can take a write only when a consuming read frees a slot.
  assign w_rdOk     = rd_en && (r_fill != '0);
  assign w_consume  = w_rdOk && !circular;
  assign w_wrOk     = wr_en && ((r_fill != FULLV) || w_consume);
  assign w_headNext = w_consume ? inc(r_head) : r_head;
  assign w_curInc   = inc(r_cur);

  always_comb begin
    w_curNext = r_cur;
    if (circular != r_circ)
      w_curNext = w_headNext;
    else if (w_consume)
      w_curNext = w_curInc;
    else if (w_rdOk)
      w_curNext = (w_curInc == r_wrPtr) ? r_head : w_curInc;
  end

  always_comb begin
    w_fillNext = r_fill;
    if (w_wrOk && !w_consume)
      w_fillNext = r_fill + FW'(1);
    else if (!w_wrOk && w_consume)
      w_fillNext = r_fill - FW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_head  <= '0;
      r_cur   <= '0;
      r_fill  <= '0;
      r_circ  <= 1'b0;
      r_over  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_circ <= circular;
      if (flush) begin
        r_wrPtr <= '0;
        r_head  <= '0;
        r_cur   <= '0;
        r_fill  <= '0;
        r_over  <= 1'b0;
        r_under <= 1'b0;
      end else begin
        r_wrPtr <= w_wrOk ? inc(r_wrPtr) : r_wrPtr;
        r_head  <= w_headNext;
        r_cur   <= w_curNext;
        r_fill  <= w_fillNext;
        r_over  <= r_over | (wr_en && !w_wrOk);
        r_under <= r_under | (rd_en && (r_fill == '0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && w_wrOk)
      r_mem[r_wrPtr] <= din;
  end

  assign dout         = r_mem[r_cur];
  assign fill_level   = r_fill;
  assign valid        = (r_fill != '0);
  assign empty        = (r_fill == '0);
  assign full         = (r_fill == FULLV);
  assign almost_full  = (int'(r_fill) >= DEPTH - ALMOST_FULL_FREE);
  assign almost_empty = (int'(r_fill) <= ALMOST_EMPTY_LEVEL);
  assign overflow     = r_over;
  assign underflow    = r_under;

endmodule

// File: tb/tb_fifo_replay.sv
// Testbench for fifo_replay (WIDTH=8, DEPTH=5): directed scenarios plus random
// traffic, compared against a queue-based model of the stored window.
module tb_fifo_replay;

  localparam int D = 5;

  logic       clk = 1'b0;
  logic       reset, flush, circular, wr_en, rd_en;
  logic [7:0] din, dout;
  logic       valid, empty, almost_empty, full, almost_full, overflow, underflow;
  logic [2:0] fill_level;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] mq[$];
  int         mOff;
  bit         mCirc, mOver, mUnder;

  fifo_replay #(.WIDTH(8), .DEPTH(D), .ALMOST_FULL_FREE(1), .ALMOST_EMPTY_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .circular(circular),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout), .valid(valid),
    .empty(empty), .almost_empty(almost_empty), .full(full),
    .almost_full(almost_full), .fill_level(fill_level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mq.delete();
    mOff = 0; mCirc = 0; mOver = 0; mUnder = 0;
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic step(input bit f, input bit c, input bit w, input logic [7:0] d, input bit r);
    int fo;
    bit rdOk, wrOk;
    flush = f; circular = c; wr_en = w; din = d; rd_en = r;
    fo = mq.size();
    if (f) begin
      mq.delete();
      mOff = 0; mOver = 0; mUnder = 0;
    end else begin
      rdOk = r && (fo > 0);
      wrOk = w && ((fo < D) || (!c && rdOk));
      if (r && fo == 0) mUnder = 1;
      if (w && !wrOk) mOver = 1;
      if (rdOk) begin
        if (!c) void'(mq.pop_front());
        else mOff = (mOff + 1 >= fo) ? 0 : mOff + 1;
      end
      if (wrOk) mq.push_back(d);
      if (c != mCirc) mOff = 0;
    end
    mCirc = c;
    @(posedge clk);
    #1;
    flush = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    reset = 0; flush = 0; circular = 0; wr_en = 0; rd_en = 0; din = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #3;
    nChecks++;
    if ({valid, empty, almost_empty, full, almost_full} !== 5'b01100) begin
      nFails++;
      $display("[TB] FAIL reset_flags got=%b want=01100", {valid, empty, almost_empty, full, almost_full});
    end
    nChecks++;
    if ({fill_level, overflow, underflow} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL reset_fill_err got=%b want=00000", {fill_level, overflow, underflow});
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 8'(i * 8'h11), 0);
      if (i == 4) begin
        nChecks++;
        if (almost_full !== 1'b1 || full !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL af_after4 got af=%b full=%b want af=1 full=0", almost_full, full);
        end
      end
    end
    nChecks++;
    if (full !== 1'b1 || fill_level !== 3'd5) begin
      nFails++;
      $display("[TB] FAIL full_after5 got full=%b fill=%0d want 1/5", full, fill_level);
    end
    step(0, 0, 1, 8'h66, 0);
    nChecks++;
    if (overflow !== 1'b1 || fill_level !== 3'd5) begin
      nFails++;
      $display("[TB] FAIL overflow6 got ovf=%b fill=%0d want 1/5", overflow, fill_level);
    end
    for (int i = 1; i <= 5; i++) begin
      nChecks++;
      if (dout !== 8'(i * 8'h11)) begin
        nFails++;
        $display("[TB] FAIL drain_order[%0d] got=%h want=%h", i, dout, 8'(i * 8'h11));
      end
      step(0, 0, 0, 0, 1);
    end
    nChecks++;
    if (empty !== 1'b1 || valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL drained_empty got empty=%b valid=%b want 1/0", empty, valid);
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 7; i++) begin
      nChecks++;
      if (dout !== 8'(8'h30 + i) || fill_level !== 3'd3) begin
        nFails++;
        $display("[TB] FAIL wrap[%0d] got dout=%h fill=%0d want %h/3", i, dout, fill_level, 8'(8'h30 + i));
      end
      step(0, 0, 1, 8'(8'h33 + i), 1);
    end
  endtask

  task automatic test_full_simul();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hD0 + i), 0);
    step(0, 0, 1, 8'hE5, 1);
    nChecks++;
    if (fill_level !== 3'd5 || overflow !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL full_rw got fill=%0d ovf=%b want 5/0", fill_level, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (dout !== ((i < 4) ? 8'(8'hD1 + i) : 8'hE5)) begin
        nFails++;
        $display("[TB] FAIL full_rw_order[%0d] got=%h want=%h", i, dout, (i < 4) ? 8'(8'hD1 + i) : 8'hE5);
      end
      step(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 8'hEE, 1);
    nChecks++;
    if (overflow !== 1'b1 || fill_level !== 3'd5) begin
      nFails++;
      $display("[TB] FAIL circ_full_write got ovf=%b fill=%0d want 1/5", overflow, fill_level);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_circular();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 8'hA1, 0);
    step(0, 0, 1, 8'hA2, 0);
    step(0, 0, 1, 8'hA3, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      nChecks++;
      if (dout !== 8'(8'hA1 + (i % 3)) || fill_level !== 3'd3) begin
        nFails++;
        $display("[TB] FAIL replay[%0d] got dout=%h fill=%0d want %h/3", i, dout, fill_level, 8'(8'hA1 + (i % 3)));
      end
      step(0, 1, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0);
    nChecks++;
    if (dout !== 8'hA1) begin
      nFails++;
      $display("[TB] FAIL replay_exit got=%h want=a1", dout);
    end
  endtask

  task automatic test_empty_rdwr();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 8'h7E, 1);
    nChecks++;
    if (underflow !== 1'b1 || fill_level !== 3'd1 || dout !== 8'h7E) begin
      nFails++;
      $display("[TB] FAIL empty_rdwr got unf=%b fill=%0d dout=%h want 1/1/7e", underflow, fill_level, dout);
    end
  endtask

  task automatic test_async_reset_flush();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i), 0);
    #2 reset = 0;
    #1;
    nChecks++;
    if (empty !== 1'b1 || fill_level !== 3'd0) begin
      nFails++;
      $display("[TB] FAIL async_reset got empty=%b fill=%0d want 1/0", empty, fill_level);
    end
    modelReset();
    #1 reset = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1);
    nChecks++;
    if (underflow !== 1'b1 || fill_level !== 3'd0) begin
      nFails++;
      $display("[TB] FAIL post_reset_rd got unf=%b fill=%0d want 1/0", underflow, fill_level);
    end
    step(0, 0, 1, 8'h01, 0);
    step(0, 0, 1, 8'h02, 0);
    step(1, 0, 1, 8'h03, 0);
    nChecks++;
    if (fill_level !== 3'd0 || underflow !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flush_write got fill=%0d unf=%b want 0/0", fill_level, underflow);
    end
  endtask

  task automatic test_random();
    bit c = 0;
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) c = ~c;
      step($urandom_range(0, 39) == 0, c, $urandom_range(0, 9) < 6,
           8'($urandom), $urandom_range(0, 1) == 1);
      nChecks++;
      if (int'(fill_level) !== mq.size() || overflow !== mOver || underflow !== mUnder) begin
        nFails++;
        $display("[TB] FAIL rand_state[%0d] got fill=%0d ovf=%b unf=%b want %0d/%b/%b",
                 n, fill_level, overflow, underflow, mq.size(), mOver, mUnder);
      end
      nChecks++;
      if ({valid, empty, full, almost_full, almost_empty} !==
          {mq.size() != 0, mq.size() == 0, mq.size() == D, mq.size() >= D - 1, mq.size() <= 1}) begin
        nFails++;
        $display("[TB] FAIL rand_flags[%0d] got=%b fill_model=%0d", n,
                 {valid, empty, full, almost_full, almost_empty}, mq.size());
      end
      if (mq.size() > 0) begin
        nChecks++;
        if (dout !== mq[mOff]) begin
          nFails++;
          $display("[TB] FAIL rand_dout[%0d] got=%h want=%h", n, dout, mq[mOff]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_circular();
    test_empty_rdwr();
    test_async_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fifo_replay.md
FIFO_REPLAY -- requirements
Module: fifo_replay

Interface
- REQ-001: Parameter WIDTH, default 32, data word width in bits (>=1).
- REQ-002: Parameter DEPTH, default 32, storage entries; SHALL be any integer >=2 (not restricted to powers of two).
- REQ-003: Parameter ALMOST_FULL_FREE, default 1, almost_full asserts when free entries <= this value.
- REQ-004: Parameter ALMOST_EMPTY_LEVEL, default 1, almost_empty asserts when fill <= this value.
- REQ-005: clk  in  1  sole clock, all state on rising edge.
- REQ-006: reset  in  1  asynchronous, active-low reset.
- REQ-007: flush  in  1  synchronous clear of contents, pointers and sticky flags.
- REQ-008: circular  in  1  replay mode: reads walk stored data without consuming it.
- REQ-009: wr_en  in  1  write request.
- REQ-010: din  in  WIDTH  write data.
- REQ-011: rd_en  in  1  read/advance request.
- REQ-012: dout  out  WIDTH  show-ahead data at the current read position.
- REQ-013: valid  out  1  dout holds a stored word.
- REQ-014: empty, almost_empty, full, almost_full  out  1 each  fill status.
- REQ-015: fill_level  out  $clog2(DEPTH+1)  stored entry count, 0..DEPTH.
- REQ-016: overflow, underflow  out  1 each  sticky error flags.

Function
- REQ-017: Three pointers SHALL be kept: wr_ptr (next write slot), head (oldest entry), cur (read position); each increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- REQ-018: A write SHALL be accepted when wr_en=1 and (fill<DEPTH, or fill=DEPTH with an accepted non-circular read in the same cycle); the word is stored at wr_ptr and wr_ptr advances.
- REQ-019: A read SHALL be accepted when rd_en=1 and fill>0 at the clock edge; writes in the same cycle do not make an empty FIFO readable.
- REQ-020: Non-circular accepted read SHALL advance head and cur together; fill decrements unless a write is also accepted (then fill unchanged).
- REQ-021: Circular accepted read SHALL advance cur only; if next cur equals wr_ptr, cur SHALL load head instead; fill and head unchanged.
- REQ-022: In circular mode a write with fill=DEPTH SHALL be rejected regardless of rd_en.
- REQ-023: When circular changes value (compared with a registered copy), cur SHALL load head on that edge; any read in that cycle is executed before the reload takes effect on the following cycle.
- REQ-024: dout SHALL equal memory[cur] combinationally from registered state; a word written into an empty FIFO appears on dout one cycle after the write edge.
- REQ-025: valid = (fill_level != 0); empty = (fill_level == 0); full = (fill_level == DEPTH); almost_full = (fill_level >= DEPTH-ALMOST_FULL_FREE); almost_empty = (fill_level <= ALMOST_EMPTY_LEVEL); all derived from registered fill only.
- REQ-026: overflow SHALL set on any rejected wr_en; underflow SHALL set on rd_en while fill=0; both hold until reset or flush.
- REQ-027: flush SHALL zero all pointers, fill and sticky flags at the edge; flush has priority over wr_en/rd_en in the same cycle; memory contents need not be cleared.

Reset
- REQ-028: While reset=0, pointers, fill_level, overflow, underflow and the registered circular copy SHALL be 0 immediately, independent of clk.
- REQ-029: Outputs during/after reset: valid=0, empty=1, almost_empty=1, full=0, almost_full=(0 >= DEPTH-ALMOST_FULL_FREE), dout don't-care.
- REQ-030: Reset asserted mid-operation SHALL discard all stored entries; the first edge after release behaves as an empty FIFO.

Verification (WIDTH=8, DEPTH=5, ALMOST_FULL_FREE=1, ALMOST_EMPTY_LEVEL=1)
- REQ-031: Write 0x11..0x55 on 5 edges -> full=1, almost_full=1 after the 4th write, fill_level=5; 6th write -> overflow=1, fill stays 5; then 5 reads -> dout 0x11..0x55 in order, empty=1.
- REQ-032: Wrap: 7 interleaved write/read pairs with fill kept at 3 -> pointers wrap past index 4, data order preserved, fill_level constant 3.
- REQ-033: Full plus simultaneous wr_en/rd_en, circular=0 -> both accepted, fill stays 5, new word appears after the 4 older ones; same with circular=1 -> write rejected, overflow=1.
- REQ-034: Store 0xA1,0xA2,0xA3, circular=1, 7 reads -> dout sequence A1 A2 A3 A1 A2 A3 A1, fill stays 3; circular=0 -> dout returns to 0xA1 next cycle.
- REQ-035: Empty with rd_en=1, wr_en=1 din=0x7E -> underflow=1, fill_level=1, dout=0x7E next cycle.
- REQ-036: Reset pulled low asynchronously between edges with fill=4 -> empty=1, fill_level=0 before the next edge; flush with wr_en=1 -> fill_level=0, write discarded.
